timekeeper_hms: RTL and testbench

TIMEKEEPER_HMS -- requirements
Module: timekeeper_hms

---
 rtl/timekeeper_pkg.sv | 15 +
 rtl/mod_counter.sv | 34 +++
 rtl/timekeeper_hms.sv | 150 +++++++++++++++
 tb/tb_timekeeper_hms.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// rtl/timekeeper_pkg.sv - shared state encoding and field constants for timekeeper_hms
package timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SET     = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int MS_W    = 6;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N counter with clear, increment, decrement and carry/borrow out
module mod_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk_1Hz,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  // carry/borrow flag the wrap that this edge will perform
  assign carry  = inc && (cnt == MAX);
  assign borrow = dec && (cnt == '0);

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= carry ? '0 : cnt + 1'b1;
    end else if (dec) begin
      cnt <= borrow ? MAX : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/timekeeper_hms.sv
// rtl/timekeeper_hms.sv - h:m:s clock/timer with set, run and expiry; TIMEKEEPER_ALARM_EN adds alarm
module timekeeper_hms
  import timekeeper_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int HOUR_W   = 5
) (
  input  logic              clk_1Hz,
  input  logic              resetn,
  input  logic              start_stop,
  input  logic              mode_in,
  input  logic              dir_down,
  input  logic              fmt_12h,
  input  logic              hour_in,
  input  logic              min_in,
  input  logic              sec_in,
  output logic [HOUR_W-1:0] hour_out,
  output logic [MS_W-1:0]   min_out,
  output logic [MS_W-1:0]   sec_out,
  output logic              pm_out,
  output logic              done_out,
  output logic [1:0]        state_out
`ifdef TIMEKEEPER_ALARM_EN
  ,
  input  logic              alarm_cap_in,
  output logic              alarm_out
`endif
);

  state_t state, state_nxt;

  logic [HOUR_W-1:0] hour_cnt;
  logic [MS_W-1:0]   min_cnt, sec_cnt;
  logic sec_carry, sec_borrow, min_carry, min_borrow, hour_carry, hour_borrow;
  logic set_mode, run_go, up_en, dn_en, at_zero, clr;
  logic fmt_q;

  assign at_zero  = (hour_cnt == '0) && (min_cnt == '0) && (sec_cnt == '0);
  assign set_mode = (state == ST_SET) && mode_in;
  assign run_go   = (state == ST_RUN) && mode_in && start_stop;
  assign up_en    = run_go && !dir_down;
  assign dn_en    = run_go && dir_down && !at_zero;
  // clear while idle and on the edge that returns to idle
  assign clr      = (state == ST_IDLE) || !mode_in;

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      fmt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      fmt_q <= fmt_12h;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (mode_in && !start_stop) state_nxt = ST_SET;
      ST_SET:     if (!mode_in) state_nxt = ST_IDLE;
                  else if (start_stop) state_nxt = ST_RUN;
      ST_RUN:     if (!mode_in) state_nxt = ST_IDLE;
                  else if (!start_stop) state_nxt = ST_SET;
                  else if (dir_down && at_zero) state_nxt = ST_EXPIRED;
      ST_EXPIRED: if (!mode_in) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  mod_counter #(.N(SEC_MOD), .W(MS_W)) u_sec (
    .clk_1Hz (clk_1Hz),
    .resetn  (resetn),
    .clr     (clr),
    .inc     ((set_mode && sec_in) || up_en),
    .dec     (dn_en),
    .cnt     (sec_cnt),
    .carry   (sec_carry),
    .borrow  (sec_borrow)
  );

  mod_counter #(.N(MIN_MOD), .W(MS_W)) u_min (
    .clk_1Hz (clk_1Hz),
    .resetn  (resetn),
    .clr     (clr),
    .inc     ((set_mode && min_in) || (up_en && sec_carry)),
    .dec     (sec_borrow),
    .cnt     (min_cnt),
    .carry   (min_carry),
    .borrow  (min_borrow)
  );

  mod_counter #(.N(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk_1Hz (clk_1Hz),
    .resetn  (resetn),
    .clr     (clr),
    .inc     ((set_mode && hour_in) || (up_en && min_carry)),
    .dec     (min_borrow),
    .cnt     (hour_cnt),
    .carry   (hour_carry),
    .borrow  (hour_borrow)
  );

  logic unused_hour_flags;
  assign unused_hour_flags = hour_carry & hour_borrow;

  logic [HOUR_W-1:0] h12;
  always_comb begin
    hour_out = hour_cnt;
    pm_out   = 1'b0;
    h12      = hour_cnt;
    if (HOUR_MOD == 24 && fmt_q) begin
      if (hour_cnt >= HOUR_W'(12)) begin
        pm_out = 1'b1;
        h12    = hour_cnt - HOUR_W'(12);
      end
      hour_out = (h12 == '0) ? HOUR_W'(12) : h12;
    end
  end

  assign min_out   = min_cnt;
  assign sec_out   = sec_cnt;
  assign done_out  = (state == ST_EXPIRED);
  assign state_out = state;

`ifdef TIMEKEEPER_ALARM_EN
  logic [HOUR_W-1:0] alarm_h;
  logic [MS_W-1:0]   alarm_m, alarm_s;
  logic              tick_q;

  // alarm registers survive IDLE; only reset clears them
  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      alarm_h <= '0;
      alarm_m <= '0;
      alarm_s <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= up_en || dn_en;
      if (set_mode && alarm_cap_in) begin
        alarm_h <= hour_cnt;
        alarm_m <= min_cnt;
        alarm_s <= sec_cnt;
      end
    end
  end

  assign alarm_out = tick_q && (hour_cnt == alarm_h) && (min_cnt == alarm_m) && (sec_cnt == alarm_s);
`endif

endmodule

// File: tb/tb_timekeeper_hms.sv
// tb/tb_timekeeper_hms.sv - self-checking bench for timekeeper_hms (24h and 12h builds side by side)
module tb_timekeeper_hms;
  import timekeeper_pkg::*;

  logic clk_1Hz = 1'b0;
  logic resetn = 1'b1;
  logic start_stop = 1'b0, mode_in = 1'b0, dir_down = 1'b0, fmt_12h = 1'b0;
  logic hour_in = 1'b0, min_in = 1'b0, sec_in = 1'b0, alarm_cap_in = 1'b0;

  logic [4:0] h24, h12;
  logic [5:0] m24, m12, s24, s12;
  logic       pm24, pm12, done24, done12, al24, al12;
  logic [1:0] st24, st12;

  int tests = 0;
  int failed = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  timekeeper_hms #(.HOUR_MOD(24), .HOUR_W(5)) dut24 (
    .clk_1Hz(clk_1Hz), .resetn(resetn), .start_stop(start_stop), .mode_in(mode_in),
    .dir_down(dir_down), .fmt_12h(fmt_12h), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(h24), .min_out(m24), .sec_out(s24), .pm_out(pm24), .done_out(done24), .state_out(st24)
`ifdef TIMEKEEPER_ALARM_EN
    , .alarm_cap_in(alarm_cap_in), .alarm_out(al24)
`endif
  );

  timekeeper_hms #(.HOUR_MOD(12), .HOUR_W(5)) dut12 (
    .clk_1Hz(clk_1Hz), .resetn(resetn), .start_stop(start_stop), .mode_in(mode_in),
    .dir_down(dir_down), .fmt_12h(fmt_12h), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_out(h12), .min_out(m12), .sec_out(s12), .pm_out(pm12), .done_out(done12), .state_out(st12)
`ifdef TIMEKEEPER_ALARM_EN
    , .alarm_cap_in(alarm_cap_in), .alarm_out(al12)
`endif
  );

`ifndef TIMEKEEPER_ALARM_EN
  assign al24 = 1'b0;
  assign al12 = 1'b0;
`endif

  // reference model: time kept as total seconds of the day
  state_t m_st[2];
  int     m_t[2];
  int     m_al[2];
  bit     m_tick[2];
  bit     m_fmt;

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = ST_IDLE; m_t[k] = 0; m_al[k] = 0; m_tick[k] = 0;
    end
    m_fmt = 0;
  endfunction

  function automatic void mstep(input int k);
    int mod, h, m, s;
    mod = (k == 0) ? 24 : 12;
    m_tick[k] = 0;
    if (m_st[k] == ST_IDLE) begin
      m_t[k] = 0;
      if (mode_in && !start_stop) m_st[k] = ST_SET;
    end else if (!mode_in) begin
      m_st[k] = ST_IDLE;
      m_t[k] = 0;
    end else if (m_st[k] == ST_SET) begin
      if (alarm_cap_in) m_al[k] = m_t[k];
      h = (m_t[k] / 3600 + int'(hour_in)) % mod;
      m = ((m_t[k] / 60) % 60 + int'(min_in)) % 60;
      s = (m_t[k] % 60 + int'(sec_in)) % 60;
      m_t[k] = h * 3600 + m * 60 + s;
      if (start_stop) m_st[k] = ST_RUN;
    end else if (m_st[k] == ST_RUN) begin
      if (!start_stop) m_st[k] = ST_SET;
      else if (!dir_down) begin
        m_t[k] = (m_t[k] + 1) % (mod * 3600);
        m_tick[k] = 1;
      end else if (m_t[k] == 0) m_st[k] = ST_EXPIRED;
      else begin
        m_t[k] = m_t[k] - 1;
        m_tick[k] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      int h, eh, epm;
      string sfx;
      sfx = (k == 0) ? "/24" : "/12";
      h = m_t[k] / 3600;
      eh = h;
      epm = 0;
      if (k == 0 && m_fmt) begin
        eh = (h % 12 == 0) ? 12 : h % 12;
        epm = (h >= 12) ? 1 : 0;
      end
      chk({tag, sfx, " state"}, (k == 0) ? 32'(st24) : 32'(st12), 32'(m_st[k]));
      chk({tag, sfx, " hour"}, (k == 0) ? 32'(h24) : 32'(h12), eh);
      chk({tag, sfx, " min"}, (k == 0) ? 32'(m24) : 32'(m12), (m_t[k] / 60) % 60);
      chk({tag, sfx, " sec"}, (k == 0) ? 32'(s24) : 32'(s12), m_t[k] % 60);
      chk({tag, sfx, " pm"}, (k == 0) ? 32'(pm24) : 32'(pm12), epm);
      chk({tag, sfx, " done"}, (k == 0) ? 32'(done24) : 32'(done12), (m_st[k] == ST_EXPIRED) ? 1 : 0);
`ifdef TIMEKEEPER_ALARM_EN
      chk({tag, sfx, " alarm"}, (k == 0) ? 32'(al24) : 32'(al12),
          (m_tick[k] && m_t[k] == m_al[k]) ? 1 : 0);
`endif
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk_1Hz);
    if (!resetn) m_reset();
    else begin
      mstep(0);
      mstep(1);
      m_fmt = fmt_12h;
    end
    @(negedge clk_1Hz);
    check_all(tag);
  endtask

  task automatic go_set();
    start_stop = 0;
    mode_in = 0;
    tick("to_idle");
    mode_in = 1;
    tick("to_set");
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int n;
    n = (h > m) ? h : m;
    n = (n > s) ? n : s;
    for (int i = 0; i < n; i++) begin
      hour_in = (i < h); min_in = (i < m); sec_in = (i < s);
      tick("set_pulse");
    end
    hour_in = 0; min_in = 0; sec_in = 0;
  endtask

  initial begin
    m_reset();
    #1 resetn = 0;
    #1 check_all("reset");
    mode_in = 1;
    start_stop = 0;
    @(negedge clk_1Hz);
    #2 resetn = 1;
    tick("rst_release_set");

    // up count across the day boundary
    go_set();
    set_time(23, 59, 58);
    start_stop = 1;
    tick("run_enter");
    tick("up_59");
    tick("up_wrap");
    tick("up_wrap_hold_run");

    // countdown to expiry and back to idle
    go_set();
    set_time(0, 1, 1);
    dir_down = 1;
    start_stop = 1;
    tick("dn_enter");
    for (int i = 0; i < 61; i++) tick("dn_count");
    tick("dn_expire");
    for (int i = 0; i < 3; i++) tick("expired_hold");
    mode_in = 0;
    tick("expired_to_idle");
    dir_down = 0;

    // entering RUN at zero while counting down expires at once
    go_set();
    dir_down = 1;
    start_stop = 1;
    tick("zero_run");
    tick("zero_expire");
    dir_down = 0;

    // 12-hour display decode
    go_set();
    fmt_12h = 1;
    tick("fmt_h0");
    set_time(13, 0, 0);
    tick("fmt_h13");
    fmt_12h = 0;
    tick("fmt_off");

    // simultaneous pulses wrap with no carry
    go_set();
    set_time(11, 59, 59);
    hour_in = 1; min_in = 1; sec_in = 1;
    tick("all_pulses");
    hour_in = 0; min_in = 0; sec_in = 0;

    // pause mid-run retains time
    go_set();
    start_stop = 1;
    tick("pause_run");
    for (int i = 0; i < 5; i++) tick("pause_count");
    start_stop = 0;
    tick("pause_set");
    tick("pause_hold");

    // asynchronous reset mid-run
    go_set();
    set_time(5, 30, 10);
    start_stop = 1;
    tick("rst_run");
    #2 resetn = 0;
    m_reset();
    #1 check_all("async_rst");
    #1 resetn = 1;
    start_stop = 0;
    tick("after_rst");

`ifdef TIMEKEEPER_ALARM_EN
    go_set();
    set_time(0, 0, 3);
    alarm_cap_in = 1;
    tick("alarm_cap");
    alarm_cap_in = 0;
    go_set();
    start_stop = 1;
    tick("alarm_run");
    for (int i = 0; i < 5; i++) tick("alarm_count");
`endif

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      mode_in = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 9) == 0) dir_down = ~dir_down;
      if ($urandom_range(0, 7) == 0) fmt_12h = ~fmt_12h;
      hour_in = ($urandom_range(0, 2) == 0);
      min_in = ($urandom_range(0, 2) == 0);
      sec_in = ($urandom_range(0, 2) == 0);
      alarm_cap_in = ($urandom_range(0, 9) == 0);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
